// File: rtl/laconic_term_scheduler_pkg.sv
// Shared constants and types for the Laconic term scheduler.
// Term records hold CSD digits of one operand in ascending exponent order.
package laconic_term_scheduler_pkg;

    localparam int unsigned N         = 16;
    localparam int unsigned MAG_W     = 7;
    localparam int unsigned EXP_W     = 3;
    localparam int unsigned MAX_TERMS = 4;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    typedef struct packed {
        logic [MAX_TERMS-1:0][EXP_W-1:0] exp;
        logic [MAX_TERMS-1:0]            sgn;
        logic [CNT_W-1:0]                cnt;
    } term_rec_t;

endpackage

// File: rtl/laconic_term_scheduler_csd_encoder.sv
// Combinational CSD (non-adjacent form) encoder: {sign, magnitude} -> signed
// power-of-two terms, lowest exponent first.
module laconic_term_scheduler_csd_encoder
    import laconic_term_scheduler_pkg::*;
(
    input  logic [MAG_W:0] operand,
    output term_rec_t      rec
);

    localparam int unsigned XW = MAG_W + 2;

    logic [XW-1:0]    x;
    logic [CNT_W-1:0] n;

    always_comb begin
        rec = '0;
        x   = XW'(operand[MAG_W-1:0]);
        n   = '0;
        for (int k = 0; k <= int'(MAG_W); k++) begin
            if (x[0]) begin
                // x mod 4 == 3 yields digit -1 (borrow upward), x mod 4 == 1 yields +1
                if (n < CNT_W'(MAX_TERMS)) begin
                    rec.exp[n[1:0]] = EXP_W'(k);
                    rec.sgn[n[1:0]] = operand[MAG_W] ^ x[1];
                end
                n = n + CNT_W'(1);
                x = x[1] ? x + XW'(1) : x - XW'(1);
            end
            x = x >> 1;
        end
        rec.cnt = n;
    end

endmodule

// File: rtl/laconic_term_scheduler.sv
// Feeds the 16-lane Laconic PE core: CSD-encodes an operand set and streams
// one (act-term, wgt-term) pair per lane per beat, i outer and j inner.
module laconic_term_scheduler
    import laconic_term_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*8-1:0]       act,
    input  logic [N*8-1:0]       wgt,
    output logic                 pe_valid,
    input  logic                 pe_ready,
    output logic [N-1:0]         in_applied,
    output logic [N*EXP_W-1:0]   t0,
    output logic [N*EXP_W-1:0]   t1,
    output logic [N-1:0]         s0,
    output logic [N-1:0]         s1,
    output logic                 pe_first,
    output logic                 pe_last
);

    state_e           state_q, state_d;
    term_rec_t        enc_a   [N];
    term_rec_t        enc_w   [N];
    term_rec_t        rec_a_q [N];
    term_rec_t        rec_w_q [N];
    logic [CNT_W-1:0] i_q     [N];
    logic [1:0]       j_q     [N];
    logic             first_q;
    logic             accept;
    logic             fire;
    logic [N-1:0]     active;
    logic [N-1:0]     lane_done;
    logic [N-1:0]     j_wrap;

    for (genvar g = 0; g < N; g++) begin : g_enc
        laconic_term_scheduler_csd_encoder u_enc_a (
            .operand (act[g*8 +: 8]),
            .rec     (enc_a[g])
        );
        laconic_term_scheduler_csd_encoder u_enc_w (
            .operand (wgt[g*8 +: 8]),
            .rec     (enc_w[g])
        );
    end

    assign in_ready = (state_q == StIdle);
    assign pe_valid = (state_q == StRun);
    assign accept   = in_ready & in_valid;
    assign fire     = pe_valid & pe_ready;
    assign pe_first = pe_valid & first_q;
    // An all-zero set has no active lane, so its single beat is also the last one.
    assign pe_last  = pe_valid & (&lane_done);

    always_comb begin
        active     = '0;
        lane_done  = '0;
        j_wrap     = '0;
        in_applied = '0;
        t0         = '0;
        t1         = '0;
        s0         = '0;
        s1         = '0;
        for (int l = 0; l < int'(N); l++) begin
            active[l] = pe_valid && (i_q[l] < rec_a_q[l].cnt) && (rec_w_q[l].cnt != '0);
            j_wrap[l] = ({1'b0, j_q[l]} == rec_w_q[l].cnt - CNT_W'(1));
            lane_done[l] = !active[l] || ((i_q[l] == rec_a_q[l].cnt - CNT_W'(1)) && j_wrap[l]);
            if (active[l]) begin
                in_applied[l]           = 1'b1;
                t0[l*EXP_W +: EXP_W]    = rec_a_q[l].exp[i_q[l][1:0]];
                t1[l*EXP_W +: EXP_W]    = rec_w_q[l].exp[j_q[l]];
                s0[l]                   = rec_a_q[l].sgn[i_q[l][1:0]];
                s1[l]                   = rec_w_q[l].sgn[j_q[l]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (fire && pe_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
            for (int l = 0; l < int'(N); l++) begin
                rec_a_q[l] <= '0;
                rec_w_q[l] <= '0;
                i_q[l]     <= '0;
                j_q[l]     <= '0;
            end
        end else if (accept) begin
            first_q <= 1'b1;
            for (int l = 0; l < int'(N); l++) begin
                rec_a_q[l] <= enc_a[l];
                rec_w_q[l] <= enc_w[l];
                i_q[l]     <= '0;
                j_q[l]     <= '0;
            end
        end else if (fire) begin
            first_q <= 1'b0;
            for (int l = 0; l < int'(N); l++) begin
                if (active[l]) begin
                    if (j_wrap[l]) begin
                        j_q[l] <= '0;
                        i_q[l] <= i_q[l] + CNT_W'(1);
                    end else begin
                        j_q[l] <= j_q[l] + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_laconic_term_scheduler.sv
// Directed bench for laconic_term_scheduler: beat contents, beat counts,
// backpressure, reset mid-set and the accumulated signed dot product.
module tb_laconic_term_scheduler;
    import laconic_term_scheduler_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*8-1:0]       act = '0;
    logic [N*8-1:0]       wgt = '0;
    logic                 pe_valid;
    logic                 pe_ready = 1'b1;
    logic [N-1:0]         in_applied;
    logic [N*EXP_W-1:0]   t0;
    logic [N*EXP_W-1:0]   t1;
    logic [N-1:0]         s0;
    logic [N-1:0]         s1;
    logic                 pe_first;
    logic                 pe_last;

    laconic_term_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .act        (act),
        .wgt        (wgt),
        .pe_valid   (pe_valid),
        .pe_ready   (pe_ready),
        .in_applied (in_applied),
        .t0         (t0),
        .t1         (t1),
        .s0         (s0),
        .s1         (s1),
        .pe_first   (pe_first),
        .pe_last    (pe_last)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     nbeats;
    longint acc;
    logic [N-1:0]       cap_app   [32];
    logic [N*EXP_W-1:0] cap_t0    [32];
    logic [N*EXP_W-1:0] cap_t1    [32];
    logic [N-1:0]       cap_s0    [32];
    logic [N-1:0]       cap_s1    [32];
    logic               cap_first [32];
    logic               cap_last  [32];
    logic [N*8-1:0]     set1, set3, set5, zero_set;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [159:0] snap();
        return 160'({in_applied, t0, t1, s0, s1, pe_first, pe_last});
    endfunction

    function automatic logic [N*8-1:0] lane(input int l, input logic [7:0] v);
        logic [N*8-1:0] r;
        r = '0;
        r[l*8 +: 8] = v;
        return r;
    endfunction

    task automatic send(input logic [N*8-1:0] a, input logic [N*8-1:0] w);
        @(negedge clk);
        check("in_ready_idle", 160'(in_ready), 160'(1));
        act      = a;
        wgt      = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Collects beats until pe_last is consumed; optionally stalls at one beat.
    task automatic collect(input int stall_beat, input int stall_cycles);
        int             cyc;
        bit             done;
        logic [159:0]   held;
        longint         term;
        nbeats = 0;
        acc    = 0;
        done   = 0;
        cyc    = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pe_valid) begin
                if (nbeats == 0) check("in_ready_busy", 160'(in_ready), 160'(0));
                if (nbeats == stall_beat && stall_cycles > 0) begin
                    pe_ready = 1'b0;
                    held     = snap();
                    repeat (stall_cycles) begin
                        @(negedge clk);
                        check("stall_hold", snap(), held);
                        check("stall_valid", 160'(pe_valid), 160'(1));
                    end
                    pe_ready = 1'b1;
                end
                if (nbeats < 32) begin
                    cap_app[nbeats]   = in_applied;
                    cap_t0[nbeats]    = t0;
                    cap_t1[nbeats]    = t1;
                    cap_s0[nbeats]    = s0;
                    cap_s1[nbeats]    = s1;
                    cap_first[nbeats] = pe_first;
                    cap_last[nbeats]  = pe_last;
                end
                for (int l = 0; l < int'(N); l++) begin
                    if (in_applied[l]) begin
                        term = longint'(1) << (int'(t0[l*EXP_W +: EXP_W]) +
                                               int'(t1[l*EXP_W +: EXP_W]));
                        acc  = (s0[l] ^ s1[l]) ? acc - term : acc + term;
                    end
                end
                if (pe_last) done = 1;
                nbeats++;
            end
        end
        if (!done) check("beat_timeout", 160'(0), 160'(1));
    endtask

    initial begin
        set1     = lane(0, 8'h03) | '0;
        zero_set = '0;
        set3     = lane(0, 8'h55) | lane(1, 8'h01);
        set5     = lane(0, 8'hFF);

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 160'(in_ready), 160'(1));
        check("rst_pe_valid", 160'(pe_valid), 160'(0));
        check("rst_outputs", snap(), 160'(0));
        rst_n = 1'b1;

        // 1: lane0 +3 x +1
        send(set1, lane(0, 8'h01));
        collect(-1, 0);
        check("s1_beats", 160'(nbeats), 160'(2));
        check("s1_b0_app", 160'(cap_app[0]), 160'(1));
        check("s1_b0_t0", 160'(cap_t0[0][2:0]), 160'(0));
        check("s1_b0_s0", 160'(cap_s0[0][0]), 160'(1));
        check("s1_b0_t1", 160'(cap_t1[0][2:0]), 160'(0));
        check("s1_b0_s1", 160'(cap_s1[0][0]), 160'(0));
        check("s1_b0_first", 160'(cap_first[0]), 160'(1));
        check("s1_b0_last", 160'(cap_last[0]), 160'(0));
        check("s1_b1_t0", 160'(cap_t0[1][2:0]), 160'(2));
        check("s1_b1_s0", 160'(cap_s0[1][0]), 160'(0));
        check("s1_b1_first", 160'(cap_first[1]), 160'(0));
        check("s1_b1_last", 160'(cap_last[1]), 160'(1));
        check("s1_sum", 160'(acc), 160'(3));

        // 2: all-zero set
        send(zero_set, zero_set);
        collect(-1, 0);
        check("s2_beats", 160'(nbeats), 160'(1));
        check("s2_app", 160'(cap_app[0]), 160'(0));
        check("s2_first", 160'(cap_first[0]), 160'(1));
        check("s2_last", 160'(cap_last[0]), 160'(1));
        check("s2_sum", 160'(acc), 160'(0));

        // 3: 85 x 85 on lane0, 1 x 1 on lane1
        send(set3, set3);
        collect(-1, 0);
        check("s3_beats", 160'(nbeats), 160'(16));
        check("s3_b0_app", 160'(cap_app[0]), 160'(3));
        check("s3_b1_app", 160'(cap_app[1]), 160'(1));
        for (int k = 0; k < 16; k++) begin
            check("s3_t0_order", 160'(cap_t0[k][2:0]), 160'(2 * (k / 4)));
            check("s3_t1_order", 160'(cap_t1[k][2:0]), 160'(2 * (k % 4)));
        end
        check("s3_b14_last", 160'(cap_last[14]), 160'(0));
        check("s3_b15_last", 160'(cap_last[15]), 160'(1));
        check("s3_sum", 160'(acc), 160'(7226));

        // 4: scenario 3 with a 3-cycle stall at beat 5
        send(set3, set3);
        collect(5, 3);
        check("s4_beats", 160'(nbeats), 160'(16));
        check("s4_b5_t0", 160'(cap_t0[5][2:0]), 160'(2));
        check("s4_b5_t1", 160'(cap_t1[5][2:0]), 160'(2));
        check("s4_sum", 160'(acc), 160'(7226));

        // 5: -127 x -1
        send(set5, lane(0, 8'h81));
        collect(-1, 0);
        check("s5_beats", 160'(nbeats), 160'(2));
        check("s5_b0_s0", 160'(cap_s0[0][0]), 160'(0));
        check("s5_b0_s1", 160'(cap_s1[0][0]), 160'(1));
        check("s5_b1_t0", 160'(cap_t0[1][2:0]), 160'(7));
        check("s5_b1_s0", 160'(cap_s0[1][0]), 160'(1));
        check("s5_sum", 160'(acc), 160'(127));

        // 6: reset during beat 5 of scenario 3, then scenario 1
        send(set3, set3);
        repeat (6) @(negedge clk);
        check("s6_pre_valid", 160'(pe_valid), 160'(1));
        check("s6_pre_t0", 160'(t0[2:0]), 160'(2));
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", 160'(pe_valid), 160'(0));
        check("s6_rst_outputs", snap(), 160'(0));
        check("s6_rst_ready", 160'(in_ready), 160'(1));
        #2 rst_n = 1'b1;
        send(set1, lane(0, 8'h01));
        collect(-1, 0);
        check("s6_beats", 160'(nbeats), 160'(2));
        check("s6_sum", 160'(acc), 160'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
